// File: rtl/apb2axi_rsp_collector_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : apb2axi_rsp_collector_if
// Description : Bus bundle for the APB2AXI response collector. It carries:
//               - the AXI B and R channels,
//               - the read-data buffer push port,
//               - the completion-queue push port.
//               Modport 'slave' is the collector's view: it receives B/R and
//               drives rdf_* and cpl_*. Modport 'master' is the surrounding
//               logic's view: the AXI fabric, the read-data buffer and the
//               completion queue.
// Ports       : none (signal bundle only)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface apb2axi_rsp_collector_if #(
    parameter int TAG_W        = 4,
    parameter int AXI_DATA_W   = 64,
    parameter int COMPLETION_W = 12 + TAG_W
);
    // AXI B channel
    logic                    bvalid;
    logic                    bready;
    logic [TAG_W-1:0]        bid;
    logic [1:0]              bresp;

    // AXI R channel
    logic                    rvalid;
    logic                    rready;
    logic [TAG_W-1:0]        rid;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    // Read-data buffer push port
    logic                    rdf_valid;
    logic                    rdf_ready;
    logic [AXI_DATA_W-1:0]   rdf_data;
    logic [TAG_W-1:0]        rdf_tag;
    logic                    rdf_last;

    // Completion queue push port
    logic                    cpl_valid;
    logic                    cpl_ready;
    logic [COMPLETION_W-1:0] cpl_entry;

    modport slave (
        input  bvalid, bid, bresp,
        output bready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready,
        output rdf_valid, rdf_data, rdf_tag, rdf_last,
        input  rdf_ready,
        output cpl_valid, cpl_entry,
        input  cpl_ready
    );

    modport master (
        output bvalid, bid, bresp,
        input  bready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready,
        input  rdf_valid, rdf_data, rdf_tag, rdf_last,
        output rdf_ready,
        input  cpl_valid, cpl_entry,
        output cpl_ready
    );
endinterface
`default_nettype wire

// File: rtl/apb2axi_rsp_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : apb2axi_rsp_collector
// Description : AXI-side response receiver of the APB2AXI converter.
//               - Forwards R beats to the read-data buffer.
//               - Accumulates the beat count and first error response per tag
//                 (AXI ID == directory tag).
//               - Emits one completion entry per finished transaction: a B
//                 handshake, or an R beat with RLAST set.
// Ports       : clk, rst_n (async, active-low)
//               bus         : apb2axi_rsp_collector_if.slave (B, R, rdf, cpl)
//               stat_*_cpl  : completion counters, present only when
//                             APB2AXI_CPL_STATS_EN is defined
// Entry       : {is_write, tag, resp[1:0], error, num_beats[7:0]}
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module apb2axi_rsp_collector #(
    parameter int TAG_NUM      = 16,
    parameter int TAG_W        = $clog2(TAG_NUM),
    parameter int AXI_DATA_W   = 64,
    parameter int COMPLETION_W = 12 + TAG_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    apb2axi_rsp_collector_if.slave     bus
`ifdef APB2AXI_CPL_STATS_EN
    ,
    output logic [15:0]                stat_wr_cpl,
    output logic [15:0]                stat_rd_cpl,
    output logic [15:0]                stat_err_cpl
`endif
);

    typedef struct packed {
        logic             is_write;
        logic [TAG_W-1:0] tag;
        logic [1:0]       resp;
        logic             error;
        logic [7:0]       num_beats;
    } completion_entry_t;

    localparam logic [7:0] c_beat_max = 8'hFF;

    // Round-robin pointer: names the source that wins when both request.
    typedef enum logic [0:0] {
        RR_B = 1'b0,
        RR_R = 1'b1
    } rr_state_t;

    rr_state_t         r_rr;
    rr_state_t         w_rr_next;

    logic              r_cpl_valid;
    completion_entry_t r_cpl_entry;
    completion_entry_t w_new_entry;

    logic [7:0]        r_beat_cnt [TAG_NUM];
    logic              r_err_seen [TAG_NUM];
    logic [1:0]        r_err_resp [TAG_NUM];

    logic              w_slot_avail;
    logic              w_b_req;
    logic              w_r_req;
    logic              w_grant_b;
    logic              w_grant_r;
    logic              w_b_fire;
    logic              w_r_beat;
    logic              w_r_last_fire;
    logic [7:0]        w_cur_cnt;

    assign w_slot_avail = !r_cpl_valid || bus.cpl_ready;
    assign w_b_req      = bus.bvalid;
    assign w_r_req      = bus.rvalid && bus.rlast && bus.rdf_ready;

    // Only completing sources compete for the slot; non-last R beats bypass it.
    always_comb begin
        w_grant_b = 1'b0;
        w_grant_r = 1'b0;
        if (w_slot_avail) begin
            if (w_b_req && w_r_req) begin
                w_grant_b = (r_rr == RR_B);
                w_grant_r = (r_rr == RR_R);
            end else begin
                w_grant_b = w_b_req;
                w_grant_r = w_r_req;
            end
        end
    end

    assign bus.bready    = w_slot_avail && w_grant_b;
    assign bus.rready    = bus.rdf_ready && (!bus.rlast || w_grant_r);
    assign bus.rdf_valid = bus.rvalid && (!bus.rlast || w_grant_r);
    assign bus.rdf_data  = bus.rdata;
    assign bus.rdf_tag   = bus.rid;
    assign bus.rdf_last  = bus.rlast;

    assign w_b_fire      = bus.bvalid && bus.bready;
    assign w_r_beat      = bus.rvalid && bus.rready;
    assign w_r_last_fire = w_r_beat && bus.rlast;
    assign w_cur_cnt     = r_beat_cnt[bus.rid];

    always_comb begin
        w_new_entry = '0;
        if (w_b_fire) begin
            w_new_entry.is_write  = 1'b1;
            w_new_entry.tag       = bus.bid;
            w_new_entry.resp      = bus.bresp;
            w_new_entry.error     = bus.bresp[1];
            w_new_entry.num_beats = 8'd1;
        end else if (w_r_last_fire) begin
            w_new_entry.is_write  = 1'b0;
            w_new_entry.tag       = bus.rid;
            // The first error seen in the burst wins over the last beat's resp.
            w_new_entry.resp      = r_err_seen[bus.rid] ? r_err_resp[bus.rid] : bus.rresp;
            w_new_entry.error     = r_err_seen[bus.rid] || bus.rresp[1];
            w_new_entry.num_beats = (w_cur_cnt == c_beat_max) ? c_beat_max : w_cur_cnt + 8'd1;
        end
    end

    // Round-robin state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= RR_B;
        end else begin
            r_rr <= w_rr_next;
        end
    end

    always_comb begin
        w_rr_next = r_rr;
        if (w_b_fire) begin
            w_rr_next = RR_R;
        end else if (w_r_last_fire) begin
            w_rr_next = RR_B;
        end
    end

    // Completion slot: a load may coincide with a pop, the new entry then stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpl_valid <= 1'b0;
            r_cpl_entry <= '0;
        end else if (w_b_fire || w_r_last_fire) begin
            r_cpl_valid <= 1'b1;
            r_cpl_entry <= w_new_entry;
        end else if (r_cpl_valid && bus.cpl_ready) begin
            r_cpl_valid <= 1'b0;
        end
    end

    assign bus.cpl_valid = r_cpl_valid;
    assign bus.cpl_entry = r_cpl_entry;

    // Per-tag burst accumulation; the last beat clears the tag for reuse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_NUM; i++) begin
                r_beat_cnt[i] <= '0;
                r_err_seen[i] <= 1'b0;
                r_err_resp[i] <= '0;
            end
        end else if (w_r_beat) begin
            if (bus.rlast) begin
                r_beat_cnt[bus.rid] <= '0;
                r_err_seen[bus.rid] <= 1'b0;
                r_err_resp[bus.rid] <= '0;
            end else begin
                if (w_cur_cnt != c_beat_max) begin
                    r_beat_cnt[bus.rid] <= w_cur_cnt + 8'd1;
                end
                if (bus.rresp[1] && !r_err_seen[bus.rid]) begin
                    r_err_seen[bus.rid] <= 1'b1;
                    r_err_resp[bus.rid] <= bus.rresp;
                end
            end
        end
    end

`ifdef APB2AXI_CPL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_cpl  <= '0;
            stat_rd_cpl  <= '0;
            stat_err_cpl <= '0;
        end else begin
            if (w_b_fire && stat_wr_cpl != 16'hFFFF) begin
                stat_wr_cpl <= stat_wr_cpl + 16'd1;
            end
            if (w_r_last_fire && stat_rd_cpl != 16'hFFFF) begin
                stat_rd_cpl <= stat_rd_cpl + 16'd1;
            end
            if ((w_b_fire || w_r_last_fire) && w_new_entry.error && stat_err_cpl != 16'hFFFF) begin
                stat_err_cpl <= stat_err_cpl + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_rsp_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_apb2axi_rsp_collector
// Description : Directed self-checking bench for apb2axi_rsp_collector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_apb2axi_rsp_collector;

    localparam int c_tag_w  = 4;
    localparam int c_data_w = 64;
    localparam int c_cpl_w  = 12 + c_tag_w;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    apb2axi_rsp_collector_if #(
        .TAG_W        (c_tag_w),
        .AXI_DATA_W   (c_data_w),
        .COMPLETION_W (c_cpl_w)
    ) bus ();

`ifdef APB2AXI_CPL_STATS_EN
    logic [15:0] stat_wr_cpl;
    logic [15:0] stat_rd_cpl;
    logic [15:0] stat_err_cpl;
`endif

    apb2axi_rsp_collector #(
        .TAG_NUM      (16),
        .TAG_W        (c_tag_w),
        .AXI_DATA_W   (c_data_w),
        .COMPLETION_W (c_cpl_w)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef APB2AXI_CPL_STATS_EN
        ,
        .stat_wr_cpl  (stat_wr_cpl),
        .stat_rd_cpl  (stat_rd_cpl),
        .stat_err_cpl (stat_err_cpl)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_cpl_w-1:0] mk_cpl(input logic iw, input logic [3:0] tag,
                                                  input logic [1:0] resp, input logic err,
                                                  input logic [7:0] nb);
        return {iw, tag, resp, err, nb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.bvalid    = 1'b0;
        bus.bid       = '0;
        bus.bresp     = 2'b00;
        bus.rvalid    = 1'b0;
        bus.rid       = '0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.rdf_ready = 1'b0;
        bus.cpl_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (bus.cpl_valid !== 1'b0) begin bad++; $display("FAIL reset_cpl_valid got=%b want=0", bus.cpl_valid); end
        total++; if (bus.cpl_entry !== '0) begin bad++; $display("FAIL reset_cpl_entry got=%h want=0", bus.cpl_entry); end
        total++; if (bus.bready !== 1'b0) begin bad++; $display("FAIL reset_bready got=%b want=0", bus.bready); end
        total++; if (bus.rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b want=0", bus.rready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_b_okay();
        logic [c_cpl_w-1:0] exp;
        bus.cpl_ready = 1'b1;
        bus.bvalid = 1'b1; bus.bid = 4'd3; bus.bresp = 2'b00;
        #1;
        total++; if (bus.bready !== 1'b1) begin bad++; $display("FAIL b_okay_bready got=%b want=1", bus.bready); end
        tick();
        bus.bvalid = 1'b0;
        exp = mk_cpl(1'b1, 4'd3, 2'b00, 1'b0, 8'd1);
        total++; if (bus.cpl_valid !== 1'b1) begin bad++; $display("FAIL b_okay_valid got=%b want=1", bus.cpl_valid); end
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL b_okay_entry got=%h want=%h", bus.cpl_entry, exp); end
        tick();
        total++; if (bus.cpl_valid !== 1'b0) begin bad++; $display("FAIL b_okay_pop got=%b want=0", bus.cpl_valid); end
        // EXOKAY is not an error; SLVERR is
        bus.bvalid = 1'b1; bus.bid = 4'd11; bus.bresp = 2'b01;
        tick();
        bus.bid = 4'd12; bus.bresp = 2'b10;
        exp = mk_cpl(1'b1, 4'd11, 2'b01, 1'b0, 8'd1);
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL b_exokay_entry got=%h want=%h", bus.cpl_entry, exp); end
        tick();
        bus.bvalid = 1'b0;
        exp = mk_cpl(1'b1, 4'd12, 2'b10, 1'b1, 8'd1);
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL b_slverr_entry got=%h want=%h", bus.cpl_entry, exp); end
        tick();
    endtask

    task automatic test_read_err();
        logic [c_cpl_w-1:0] exp;
        logic [63:0]        d;
        int                 pushes;
        pushes = 0;
        bus.cpl_ready = 1'b1;
        bus.rdf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 64'h0123_4567_89AB_CD00 + 64'(i);
            bus.rvalid = 1'b1; bus.rid = 4'd5; bus.rdata = d;
            bus.rresp = (i == 1) ? 2'b10 : 2'b00;
            bus.rlast = (i == 3);
            #1;
            if (bus.rdf_valid === 1'b1 && bus.rready === 1'b1) pushes++;
            total++; if (bus.rdf_last !== (i == 3)) begin bad++; $display("FAIL rd_err_last beat=%0d got=%b want=%b", i, bus.rdf_last, (i == 3)); end
            total++; if (bus.rdf_data !== d || bus.rdf_tag !== 4'd5) begin bad++; $display("FAIL rd_err_data beat=%0d got=%h/%h want=%h/5", i, bus.rdf_data, bus.rdf_tag, d); end
            tick();
        end
        idle();
        total++; if (pushes !== 4) begin bad++; $display("FAIL rd_err_pushes got=%0d want=4", pushes); end
        exp = mk_cpl(1'b0, 4'd5, 2'b10, 1'b1, 8'd4);
        total++; if (bus.cpl_valid !== 1'b1 || bus.cpl_entry !== exp) begin bad++; $display("FAIL rd_err_entry got=%b/%h want=1/%h", bus.cpl_valid, bus.cpl_entry, exp); end
        tick();
    endtask

    task automatic test_interleave();
        logic [3:0] tags [5];
        logic       lasts [5];
        logic [c_cpl_w-1:0] exp;
        tags  = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
        lasts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.cpl_ready = 1'b1;
        bus.rdf_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rvalid = 1'b1; bus.rid = tags[i]; bus.rresp = 2'b00; bus.rlast = lasts[i];
            bus.rdata = 64'(i);
            #1;
            total++; if (bus.rready !== 1'b1) begin bad++; $display("FAIL ilv_rready beat=%0d got=%b want=1", i, bus.rready); end
            tick();
            if (i == 3) begin
                exp = mk_cpl(1'b0, 4'd2, 2'b00, 1'b0, 8'd2);
                total++; if (bus.cpl_valid !== 1'b1 || bus.cpl_entry !== exp) begin bad++; $display("FAIL ilv_tag2 got=%b/%h want=1/%h", bus.cpl_valid, bus.cpl_entry, exp); end
            end else if (i == 4) begin
                exp = mk_cpl(1'b0, 4'd1, 2'b00, 1'b0, 8'd3);
                total++; if (bus.cpl_valid !== 1'b1 || bus.cpl_entry !== exp) begin bad++; $display("FAIL ilv_tag1 got=%b/%h want=1/%h", bus.cpl_valid, bus.cpl_entry, exp); end
            end else begin
                total++; if (bus.cpl_valid !== 1'b0) begin bad++; $display("FAIL ilv_nocpl beat=%0d got=%b want=0", i, bus.cpl_valid); end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_arbitration();
        logic [c_cpl_w-1:0] exp;
        bus.cpl_ready = 1'b1;
        bus.rdf_ready = 1'b1;
        bus.bvalid = 1'b1; bus.bid = 4'd7; bus.bresp = 2'b00;
        bus.rvalid = 1'b1; bus.rid = 4'd9; bus.rresp = 2'b00; bus.rlast = 1'b1;
        #1;
        total++; if (bus.bready !== 1'b1 || bus.rready !== 1'b0 || bus.rdf_valid !== 1'b0) begin bad++; $display("FAIL arb_first got=b%b r%b v%b want=b1 r0 v0", bus.bready, bus.rready, bus.rdf_valid); end
        tick();
        bus.bvalid = 1'b0;
        #1;
        exp = mk_cpl(1'b1, 4'd7, 2'b00, 1'b0, 8'd1);
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL arb_b_entry got=%h want=%h", bus.cpl_entry, exp); end
        total++; if (bus.rready !== 1'b1) begin bad++; $display("FAIL arb_r_next got=%b want=1", bus.rready); end
        tick();
        idle();
        exp = mk_cpl(1'b0, 4'd9, 2'b00, 1'b0, 8'd1);
        total++; if (bus.cpl_valid !== 1'b1 || bus.cpl_entry !== exp) begin bad++; $display("FAIL arb_r_entry got=%b/%h want=1/%h", bus.cpl_valid, bus.cpl_entry, exp); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [c_cpl_w-1:0] exp;
        bus.cpl_ready = 1'b0;
        bus.rdf_ready = 1'b1;
        bus.bvalid = 1'b1; bus.bid = 4'd2; bus.bresp = 2'b00;
        tick();
        bus.bid = 4'd6;
        bus.rvalid = 1'b1; bus.rid = 4'd8; bus.rlast = 1'b0; bus.rresp = 2'b00;
        #1;
        total++; if (bus.cpl_valid !== 1'b1) begin bad++; $display("FAIL bp_full got=%b want=1", bus.cpl_valid); end
        total++; if (bus.bready !== 1'b0 || bus.rready !== 1'b1 || bus.rdf_valid !== 1'b1) begin bad++; $display("FAIL bp_nonlast got=b%b r%b v%b want=b0 r1 v1", bus.bready, bus.rready, bus.rdf_valid); end
        bus.rdf_ready = 1'b0;
        #1;
        total++; if (bus.rready !== 1'b0) begin bad++; $display("FAIL bp_rdf_stall got=%b want=0", bus.rready); end
        bus.rdf_ready = 1'b1;
        tick();
        bus.rlast = 1'b1;
        #1;
        total++; if (bus.rready !== 1'b0 || bus.rdf_valid !== 1'b0 || bus.bready !== 1'b0) begin bad++; $display("FAIL bp_last_stall got=r%b v%b b%b want=r0 v0 b0", bus.rready, bus.rdf_valid, bus.bready); end
        tick();
        exp = mk_cpl(1'b1, 4'd2, 2'b00, 1'b0, 8'd1);
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL bp_hold got=%h want=%h", bus.cpl_entry, exp); end
        // Release: pointer is at R after the bid=2 grant, so R last goes first.
        bus.cpl_ready = 1'b1;
        #1;
        total++; if (bus.rready !== 1'b1 || bus.bready !== 1'b0) begin bad++; $display("FAIL bp_release got=r%b b%b want=r1 b0", bus.rready, bus.bready); end
        tick();
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        exp = mk_cpl(1'b0, 4'd8, 2'b00, 1'b0, 8'd2);
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL bp_drain_r got=%h want=%h", bus.cpl_entry, exp); end
        tick();
        bus.bvalid = 1'b0;
        exp = mk_cpl(1'b1, 4'd6, 2'b00, 1'b0, 8'd1);
        total++; if (bus.cpl_valid !== 1'b1 || bus.cpl_entry !== exp) begin bad++; $display("FAIL bp_drain_b got=%b/%h want=1/%h", bus.cpl_valid, bus.cpl_entry, exp); end
        tick();
        idle();
        total++; if (bus.cpl_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", bus.cpl_valid); end
    endtask

    task automatic test_saturation();
        logic [c_cpl_w-1:0] exp;
        bus.cpl_ready = 1'b1;
        bus.rdf_ready = 1'b1;
        bus.rvalid = 1'b1; bus.rid = 4'd10; bus.rresp = 2'b00; bus.rlast = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        bus.rlast = 1'b1;
        tick();
        idle();
        exp = mk_cpl(1'b0, 4'd10, 2'b00, 1'b0, 8'd255);
        total++; if (bus.cpl_entry !== exp) begin bad++; $display("FAIL sat_entry got=%h want=%h", bus.cpl_entry, exp); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [c_cpl_w-1:0] exp;
        bus.cpl_ready = 1'b1;
        bus.rdf_ready = 1'b1;
        bus.rvalid = 1'b1; bus.rid = 4'd4; bus.rlast = 1'b0; bus.rresp = 2'b10;
        tick();
        bus.rresp = 2'b00;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        total++; if (bus.cpl_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bus.cpl_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        bus.rvalid = 1'b1; bus.rid = 4'd4; bus.rlast = 1'b1; bus.rresp = 2'b00;
        tick();
        idle();
        exp = mk_cpl(1'b0, 4'd4, 2'b00, 1'b0, 8'd1);
        total++; if (bus.cpl_valid !== 1'b1 || bus.cpl_entry !== exp) begin bad++; $display("FAIL mid_rst_entry got=%b/%h want=1/%h", bus.cpl_valid, bus.cpl_entry, exp); end
`ifdef APB2AXI_CPL_STATS_EN
        total++; if (stat_wr_cpl !== 16'd0 || stat_rd_cpl !== 16'd1 || stat_err_cpl !== 16'd0) begin bad++; $display("FAIL stats got=%0d/%0d/%0d want=0/1/0", stat_wr_cpl, stat_rd_cpl, stat_err_cpl); end
`endif
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_b_okay();
        test_read_err();
        test_interleave();
        test_arbitration();
        test_backpressure();
        test_saturation();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
